// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS time-keeping core: divides clk down to a 1 Hz tick and keeps six BCD digits,
// with a two-button set mode (mode steps RUN -> SET_HR -> SET_MIN -> RUN, inc bumps the selected field).
module bcd_time_counter #(
    parameter int CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_e;

    mode_e         state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          btn_mode_q, btn_inc_q;
    logic          mode_edge, inc_edge;
    logic [3:0]    sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
    logic [3:0]    min_lo_q, min_lo_d, min_hi_q, min_hi_d;
    logic [3:0]    hr_lo_q, hr_lo_d, hr_hi_q, hr_hi_d;
    logic          sec_tick_q, sec_tick_d;
    logic [8:0]    sec_inc, min_inc;
    logic [7:0]    hr_inc;

    // Two-digit BCD increment 00..59; bit 8 is the carry out of 59 -> 00.
    function automatic logic [8:0] inc_mod60(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        logic       c;
        hi = v[7:4];
        lo = v[3:0];
        c  = 1'b0;
        if (lo == 4'd9) begin
            lo = 4'd0;
            if (hi == 4'd5) begin
                hi = 4'd0;
                c  = 1'b1;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {c, hi, lo};
    endfunction

    function automatic logic [7:0] inc_mod24(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (hi == 4'd2 && lo == 4'd3) begin
            hi = 4'd0;
            lo = 4'd0;
        end else if (lo == 4'd9) begin
            lo = 4'd0;
            hi = hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc & ~btn_inc_q;

    assign sec_inc = inc_mod60({sec_hi_q, sec_lo_q});
    assign min_inc = inc_mod60({min_hi_q, min_lo_q});
    assign hr_inc  = inc_mod24({hr_hi_q, hr_lo_q});

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_tick_d = 1'b0;
        sec_lo_d   = sec_lo_q;
        sec_hi_d   = sec_hi_q;
        min_lo_d   = min_lo_q;
        min_hi_d   = min_hi_q;
        hr_lo_d    = hr_lo_q;
        hr_hi_d    = hr_hi_q;

        case (state_q)
            RUN: begin
                // A mode edge takes priority over a coinciding tick: enter set mode with the prescaler cleared.
                if (mode_edge) begin
                    state_d = SET_HR;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d    = '0;
                    sec_tick_d = 1'b1;
                    {sec_hi_d, sec_lo_d} = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        {min_hi_d, min_lo_d} = min_inc[7:0];
                        if (min_inc[8]) begin
                            {hr_hi_d, hr_lo_d} = hr_inc;
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            SET_HR: begin
                presc_d = '0;
                if (mode_edge) begin
                    state_d = SET_MIN;
                end else if (inc_edge) begin
                    {hr_hi_d, hr_lo_d} = hr_inc;
                end
            end
            SET_MIN: begin
                presc_d = '0;
                if (mode_edge) begin
                    state_d  = RUN;
                    sec_lo_d = 4'd0;
                    sec_hi_d = 4'd0;
                end else if (inc_edge) begin
                    {min_hi_d, min_lo_d} = min_inc[7:0];
                end
            end
            default: begin
                state_d = RUN;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            presc_q    <= '0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            sec_lo_q   <= 4'd0;
            sec_hi_q   <= 4'd0;
            min_lo_q   <= 4'd0;
            min_hi_q   <= 4'd0;
            hr_lo_q    <= 4'd0;
            hr_hi_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            sec_tick_q <= sec_tick_d;
            sec_lo_q   <= sec_lo_d;
            sec_hi_q   <= sec_hi_d;
            min_lo_q   <= min_lo_d;
            min_hi_q   <= min_hi_d;
            hr_lo_q    <= hr_lo_d;
            hr_hi_q    <= hr_hi_d;
        end
    end

    assign sec_lo   = sec_lo_q;
    assign sec_hi   = sec_hi_q;
    assign min_lo   = min_lo_q;
    assign min_hi   = min_hi_q;
    assign hr_lo    = hr_lo_q;
    assign hr_hi    = hr_hi_q;
    assign mode     = state_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: an integer seconds-of-day model predicts every cycle into a scoreboard,
// plus directed checks for tick timing, carries, set mode and asynchronous reset.
module tb_bcd_time_counter;

    localparam int CLK_DIV = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [1:0] mode;
    logic       sec_tick;

    bcd_time_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_lo   (sec_lo),
        .sec_hi   (sec_hi),
        .min_lo   (min_lo),
        .min_hi   (min_hi),
        .hr_lo    (hr_lo),
        .hr_hi    (hr_hi),
        .mode     (mode),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int m_hr, m_min, m_sec, m_mode, m_presc;
    bit m_tick, m_bmq, m_biq;

    logic [26:0] exp_q[$];
    logic [26:0] obs;
    logic [23:0] digits;

    assign digits = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
    assign obs    = {digits, mode, sec_tick};

    function automatic logic [26:0] pack(int h, int m, int s, int md, bit t);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 2'(md), t};
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_hr = 0; m_min = 0; m_sec = 0; m_mode = 0; m_presc = 0;
        m_tick = 0; m_bmq = 0; m_biq = 0;
    endtask

    task automatic model_step(bit bm, bit bi);
        bit me, ie;
        int t;
        me = bm && !m_bmq;
        ie = bi && !m_biq;
        m_bmq  = bm;
        m_biq  = bi;
        m_tick = 0;
        case (m_mode)
            0: begin
                if (me) begin
                    m_mode  = 1;
                    m_presc = 0;
                end else if (m_presc == CLK_DIV - 1) begin
                    m_presc = 0;
                    m_tick  = 1;
                    t = (m_hr * 3600 + m_min * 60 + m_sec + 1) % 86400;
                    m_hr  = t / 3600;
                    m_min = (t / 60) % 60;
                    m_sec = t % 60;
                end else begin
                    m_presc++;
                end
            end
            1: begin
                if (me) m_mode = 2;
                else if (ie) m_hr = (m_hr + 1) % 24;
            end
            default: begin
                if (me) begin
                    m_mode = 0;
                    m_sec  = 0;
                end else if (ie) begin
                    m_min = (m_min + 1) % 60;
                end
            end
        endcase
    endtask

    // One clock transaction: drive buttons, predict, then compare after the edge.
    task automatic cyc(bit bm, bit bi);
        logic [26:0] e;
        btn_mode = bm;
        btn_inc  = bi;
        model_step(bm, bi);
        exp_q.push_back(pack(m_hr, m_min, m_sec, m_mode, m_tick));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("cycle", {5'd0, obs}, {5'd0, e});
    endtask

    task automatic press_mode();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        $display("mode press -> mode=%0d time=%h", mode, digits);
    endtask

    task automatic press_inc();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        $display("inc press  -> mode=%0d time=%h", mode, digits);
    endtask

    task automatic run(int n);
        repeat (n) cyc(1'b0, 1'b0);
        $display("run %0d cycles -> time=%h", n, digits);
    endtask

    task automatic do_reset();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_eq("reset_async", {5'd0, obs}, 32'd0);
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hold", {5'd0, obs}, 32'd0);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    initial begin
        int ticks;
        int tick_at;

        @(posedge clk);
        #1;
        do_reset();

        // Tick timing and seconds carry.
        ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0, 1'b0);
            if (sec_tick) ticks++;
            if (i == 3) check_eq("tp1_before_tick", {28'd0, sec_lo}, 32'd0);
            if (i == 4) check_eq("tp1_first_tick", {28'd0, sec_lo}, 32'd1);
        end
        check_eq("tp1_tick_count", ticks, 10);
        check_eq("tp1_sec_10", {24'd0, sec_hi, sec_lo}, 32'h10);

        // Set 23:59 then roll over 23:59:59 -> 00:00:00.
        press_mode();
        repeat (23) press_inc();
        press_mode();
        repeat (59) press_inc();
        cyc(1'b1, 1'b0);
        check_eq("tp2_exit", {5'd0, obs}, {5'd0, pack(23, 59, 0, 0, 1'b0)});
        cyc(1'b0, 1'b0);
        run(238);
        check_eq("tp2_235959", {8'd0, digits}, 32'h235959);
        run(1);
        check_eq("tp2_rollover", {8'd0, digits}, 32'h000000);
        check_eq("tp2_mode", {30'd0, mode}, 32'd0);

        // Hours modulo 24 and held button.
        press_mode();
        repeat (25) press_inc();
        check_eq("tp3_hr_25", {24'd0, hr_hi, hr_lo}, 32'h01);
        repeat (10) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check_eq("tp3_hr_hold", {24'd0, hr_hi, hr_lo}, 32'h02);
        check_eq("tp3_min_sec", {16'd0, min_hi, min_lo, sec_hi, sec_lo}, 32'h0000);

        // Simultaneous mode and inc edges: mode wins.
        press_mode();
        repeat (7) press_inc();
        check_eq("tp4_min_07", {24'd0, min_hi, min_lo}, 32'h07);
        cyc(1'b1, 1'b1);
        check_eq("tp4_mode", {30'd0, mode}, 32'd0);
        check_eq("tp4_time", {8'd0, digits}, 32'h020700);
        cyc(1'b0, 1'b0);

        // Seconds cleared on set-mode exit, next tick CLK_DIV cycles later.
        do_reset();
        run(37 * CLK_DIV);
        check_eq("tp5_sec_37", {24'd0, sec_hi, sec_lo}, 32'h37);
        press_mode();
        press_mode();
        cyc(1'b1, 1'b0);
        check_eq("tp5_sec_cleared", {24'd0, sec_hi, sec_lo}, 32'h00);
        check_eq("tp5_mode", {30'd0, mode}, 32'd0);
        tick_at = -1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0);
            if (sec_tick && tick_at < 0) tick_at = i;
        end
        check_eq("tp5_tick_latency", tick_at, CLK_DIV);

        // Asynchronous reset in SET_MIN at 12:34:56.
        do_reset();
        run(56 * CLK_DIV);
        press_mode();
        repeat (12) press_inc();
        press_mode();
        repeat (34) press_inc();
        check_eq("tp6_time", {8'd0, digits}, 32'h123456);
        check_eq("tp6_mode", {30'd0, mode}, 32'd2);
        do_reset();
        run(2 * CLK_DIV);
        check_eq("tp6_restart_sec", {28'd0, sec_lo}, 32'd2);
        check_eq("tp6_restart_tick", {31'd0, sec_tick}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
